multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are clk and rst.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  6  IR[31:26]; stable from DECODE until instruction end.
REQ-005 zero  in  1  ALU zero flag, combinational, same cycle.
REQ-006 mem_ready  in  1  memory completion strobe for the current request.
REQ-007 mem_req, mem_we, iord  out  1 each  memory request, write enable, address select (0=PC, 1=ALUOut).
REQ-008 ir_write, pc_write, reg_write  out  1 each  IR load, PC load, register-file write.
REQ-009 pc_src  out  2  00=ALU, 01=ALUOut (branch target), 10=jump target.
REQ-010 alu_src_a  out  1  0=PC, 1=rs; alu_src_b  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2.
REQ-011 alu_op  out  3  000 ADD, 001 SUB, 010 FUNCT, 011 AND, 100 OR, 101 XOR, 110 LUI.
REQ-012 reg_dst  out  2  00=rt, 01=rd, 10=r31; mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=PC.
REQ-013 ext_zero  out  1  1=zero-extend immediate.
REQ-014 instr_done  out  1  one-cycle pulse on an instruction's final cycle.
REQ-015 trap  out  1  illegal opcode seen; state  out  4  current state code; instr_count  out  32  retired instructions.

Function
REQ-016 Moore FSM, 4-bit state: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, R_WB=8, EXEC_I=9, I_WB=10, BRANCH=11, JUMP=12, JAL=13, TRAP=14.
REQ-017 Outputs SHALL be combinational from state (plus mem_ready, zero, opcode where stated); any output not listed for a state SHALL be 0.
REQ-018 IDLE: all outputs 0; next FETCH.
REQ-019 FETCH: mem_req=1, iord=0, alu_src_b=01, alu_op=ADD; ir_write=pc_write=mem_ready; hold until mem_ready=1, then DECODE.
REQ-020 DECODE: alu_src_b=11, alu_op=ADD; next by opcode: 100011/101011→MEM_ADDR; 000000→EXEC_R; 000100/000101→BRANCH; 001000/001100/001101/001110/001111→EXEC_I; 000010→JUMP; 000011→JAL; other→TRAP.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; lw→MEM_RD, sw→MEM_WR.
REQ-022 MEM_RD: mem_req=1, iord=1; hold until mem_ready, then MEM_WB.
REQ-023 MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1; next FETCH.
REQ-024 MEM_WR: mem_req=mem_we=iord=1; hold until mem_ready; instr_done=mem_ready; then FETCH.
REQ-025 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=FUNCT; next R_WB; R_WB: reg_write=1, reg_dst=01, instr_done=1; next FETCH.
REQ-026 EXEC_I: alu_src_a=1, alu_src_b=10; alu_op addi ADD, andi AND, ori OR, xori XOR, lui LUI; ext_zero=1 for andi/ori/xori; next I_WB; I_WB: reg_write=1, reg_dst=00, mem_to_reg=00, ext_zero as EXEC_I, instr_done=1; next FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; pc_write=zero (beq) or ~zero (bne); instr_done=1; next FETCH.
REQ-028 JUMP: pc_src=10, pc_write=1, instr_done=1; JAL additionally reg_write=1, reg_dst=10, mem_to_reg=10; both next FETCH.
REQ-029 TRAP: trap=1, all else 0; remains until rst.
REQ-030 instr_count SHALL increment by 1 on each clock edge where instr_done=1, wrapping 0xFFFFFFFF→0.
REQ-031 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-032 Minimum latency in cycles: R/I-ALU 4, lw 5, sw 4, branch/jump 3 (mem_ready immediate); each mem_ready=0 cycle adds one.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, instr_count=0, all outputs 0, including mid-instruction and mid-memory wait.
REQ-034 After rst deasserts, the first rising edge SHALL move IDLE→FETCH.

Verification
REQ-035 Reset release, mem_ready=1, opcode=000000: states 1,2,7,8,1; instr_done in R_WB; instr_count=1.
REQ-036 lw with mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles, MEM_WB reg_write=1, mem_to_reg=01; total 8 cycles.
REQ-037 beq zero=1 → pc_write=1, pc_src=01; bne zero=1 → pc_write=0; both return to FETCH.
REQ-038 opcode=111111 → TRAP, trap=1 for 10+ cycles, instr_count unchanged, no mem_req.
REQ-039 rst asserted during MEM_WR wait → mem_req/mem_we drop same cycle, state=0, instr_count=0.
REQ-040 instr_count preloaded near 0xFFFFFFFF via back-to-back j → wraps to 0; JAL asserts reg_dst=10, mem_to_reg=10, pc_write=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode,
// execute, memory and write-back, plus a retired-instruction counter.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        ext_zero,
  output logic        instr_done,
  output logic        trap,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd6;
  localparam logic [STATE_W-1:0] S_EXEC_R   = 4'd7;
  localparam logic [STATE_W-1:0] S_R_WB     = 4'd8;
  localparam logic [STATE_W-1:0] S_EXEC_I   = 4'd9;
  localparam logic [STATE_W-1:0] S_I_WB     = 4'd10;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd11;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'd12;
  localparam logic [STATE_W-1:0] S_JAL      = 4'd13;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               i_logical;
  logic [2:0]         i_alu_op;

  // Immediate-class decode shared by EXEC_I and I_WB.
  always_comb begin
    i_logical = 1'b0;
    i_alu_op  = ALU_ADD;
    case (opcode)
      OP_ANDI: begin i_alu_op = ALU_AND; i_logical = 1'b1; end
      OP_ORI:  begin i_alu_op = ALU_OR;  i_logical = 1'b1; end
      OP_XORI: begin i_alu_op = ALU_XOR; i_logical = 1'b1; end
      OP_LUI:  i_alu_op = ALU_LUI;
      default: i_alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state and Moore outputs; mem_ready only matters in memory-wait states.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    ext_zero   = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                           state_d = S_MEM_ADDR;
          OP_RTYPE:                               state_d = S_EXEC_R;
          OP_BEQ, OP_BNE:                         state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_EXEC_I;
          OP_J:                                   state_d = S_JUMP;
          OP_JAL:                                 state_d = S_JAL;
          default:                                state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = i_alu_op;
        ext_zero  = i_logical;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write  = 1'b1;
        ext_zero   = i_logical;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // Illegal opcode: park here until reset.
      S_TRAP: trap = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_count_d = instr_done ? instr_count_q + CNT_W'(1) : instr_count_q;

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each task drives one scenario
// and compares outputs against hand-derived values.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic        alu_src_a, ext_zero, instr_done, trap;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ext_zero(ext_zero),
    .instr_done(instr_done), .trap(trap), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Leaves the DUT in IDLE, 2 time units after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    #1;
    n_total++; if (state !== 4'd0 || instr_count !== 32'd0) $display("FAIL reset_state: state=%0d count=%0d exp 0/0", state, instr_count); else n_pass++;
    n_total++; if ({mem_req, mem_we, iord, ir_write, pc_write, reg_write, trap, instr_done} !== 8'b0) $display("FAIL reset_outs: got %b exp 0", {mem_req, mem_we, iord, ir_write, pc_write, reg_write, trap, instr_done}); else n_pass++;
    step();
    n_total++; if (state !== 4'd0) $display("FAIL reset_hold: state=%0d exp 0", state); else n_pass++;
  endtask

  task automatic test_r_type();
    opcode = 6'b000000; mem_ready = 1'b1;
    rst = 1'b0;
    step();
    n_total++; if (state !== 4'd1 || mem_req !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01 || iord !== 1'b0) $display("FAIL r_fetch: state=%0d req=%b irw=%b pcw=%b srcb=%b exp 1/1/1/1/01", state, mem_req, ir_write, pc_write, alu_src_b); else n_pass++;
    step();
    n_total++; if (state !== 4'd2 || alu_src_b !== 2'b11 || alu_op !== 3'b000 || mem_req !== 1'b0) $display("FAIL r_decode: state=%0d srcb=%b op=%b exp 2/11/000", state, alu_src_b, alu_op); else n_pass++;
    step();
    n_total++; if (state !== 4'd7 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00 || alu_op !== 3'b010) $display("FAIL r_exec: state=%0d srca=%b srcb=%b op=%b exp 7/1/00/010", state, alu_src_a, alu_src_b, alu_op); else n_pass++;
    step();
    n_total++; if (state !== 4'd8 || reg_write !== 1'b1 || reg_dst !== 2'b01 || instr_done !== 1'b1 || instr_count !== 32'd0) $display("FAIL r_wb: state=%0d rw=%b dst=%b done=%b cnt=%0d exp 8/1/01/1/0", state, reg_write, reg_dst, instr_done, instr_count); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd1) $display("FAIL r_retire: state=%0d cnt=%0d exp 1/1", state, instr_count); else n_pass++;
  endtask

  task automatic test_lw_wait();
    int cycles;
    do_reset();
    opcode = 6'b100011; mem_ready = 1'b1;
    step();
    cycles = 1;
    step(); cycles++;
    step(); cycles++;
    n_total++; if (state !== 4'd3 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10 || alu_op !== 3'b000) $display("FAIL lw_addr: state=%0d srca=%b srcb=%b exp 3/1/10", state, alu_src_a, alu_src_b); else n_pass++;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); cycles++;
      n_total++; if (state !== 4'd4 || mem_req !== 1'b1 || iord !== 1'b1 || instr_done !== 1'b0) $display("FAIL lw_rd_wait%0d: state=%0d req=%b iord=%b exp 4/1/1", i, state, mem_req, iord); else n_pass++;
    end
    mem_ready = 1'b1;
    step(); cycles++;
    n_total++; if (state !== 4'd5 || reg_write !== 1'b1 || mem_to_reg !== 2'b01 || reg_dst !== 2'b00 || instr_done !== 1'b1) $display("FAIL lw_wb: state=%0d rw=%b m2r=%b done=%b exp 5/1/01/1", state, reg_write, mem_to_reg, instr_done); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || cycles !== 8 || instr_count !== 32'd1) $display("FAIL lw_total: state=%0d cycles=%0d cnt=%0d exp 1/8/1", state, cycles, instr_count); else n_pass++;
  endtask

  task automatic test_itype();
    do_reset();
    opcode = 6'b001100; mem_ready = 1'b1;
    step(); step(); step();
    n_total++; if (state !== 4'd9 || alu_op !== 3'b011 || ext_zero !== 1'b1 || alu_src_b !== 2'b10 || alu_src_a !== 1'b1) $display("FAIL andi_exec: state=%0d op=%b ez=%b exp 9/011/1", state, alu_op, ext_zero); else n_pass++;
    step();
    n_total++; if (state !== 4'd10 || reg_write !== 1'b1 || ext_zero !== 1'b1 || instr_done !== 1'b1 || reg_dst !== 2'b00) $display("FAIL andi_wb: state=%0d rw=%b ez=%b done=%b exp 10/1/1/1", state, reg_write, ext_zero, instr_done); else n_pass++;
    step();
    opcode = 6'b001111;
    step(); step();
    n_total++; if (state !== 4'd9 || alu_op !== 3'b110 || ext_zero !== 1'b0) $display("FAIL lui_exec: state=%0d op=%b ez=%b exp 9/110/0", state, alu_op, ext_zero); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    opcode = 6'b000100; mem_ready = 1'b1; zero = 1'b1;
    step(); step(); step();
    n_total++; if (state !== 4'd11 || pc_write !== 1'b1 || pc_src !== 2'b01 || alu_op !== 3'b001 || instr_done !== 1'b1) $display("FAIL beq_taken: state=%0d pcw=%b src=%b op=%b exp 11/1/01/001", state, pc_write, pc_src, alu_op); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd1) $display("FAIL beq_ret: state=%0d cnt=%0d exp 1/1", state, instr_count); else n_pass++;
    opcode = 6'b000101;
    step(); step();
    n_total++; if (state !== 4'd11 || pc_write !== 1'b0) $display("FAIL bne_zero1: state=%0d pcw=%b exp 11/0", state, pc_write); else n_pass++;
    zero = 1'b0; #1;
    n_total++; if (pc_write !== 1'b1 || pc_src !== 2'b01) $display("FAIL bne_zero0: pcw=%b src=%b exp 1/01", pc_write, pc_src); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd2) $display("FAIL bne_ret: state=%0d cnt=%0d exp 1/2", state, instr_count); else n_pass++;
  endtask

  task automatic test_trap();
    int bad;
    do_reset();
    opcode = 6'b111111; mem_ready = 1'b1;
    step(); step(); step();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; #1;
      if (state !== 4'd14 || trap !== 1'b1 || mem_req !== 1'b0 || instr_count !== 32'd0 || instr_done !== 1'b0) bad++;
      step();
    end
    n_total++; if (bad !== 0) $display("FAIL trap_hold: %0d bad cycles, state=%0d trap=%b req=%b exp 0 bad", bad, state, trap, mem_req); else n_pass++;
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = 6'b101011; mem_ready = 1'b0;
    step();
    n_total++; if (state !== 4'd1 || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_req !== 1'b1) $display("FAIL fetch_wait: state=%0d irw=%b pcw=%b exp 1/0/0", state, ir_write, pc_write); else n_pass++;
    step();
    n_total++; if (state !== 4'd1) $display("FAIL fetch_hold: state=%0d exp 1", state); else n_pass++;
    mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();
    n_total++; if (state !== 4'd6 || mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1 || instr_done !== 1'b0) $display("FAIL sw_wait: state=%0d req=%b we=%b done=%b exp 6/1/1/0", state, mem_req, mem_we, instr_done); else n_pass++;
    mem_ready = 1'b1; #1;
    n_total++; if (instr_done !== 1'b1) $display("FAIL sw_done: done=%b exp 1", instr_done); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd1) $display("FAIL sw_ret: state=%0d cnt=%0d exp 1/1", state, instr_count); else n_pass++;
    step(); step();
    mem_ready = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    n_total++; if (state !== 4'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 || instr_count !== 32'd0) $display("FAIL rst_mid_wr: state=%0d req=%b we=%b cnt=%0d exp 0/0/0/0", state, mem_req, mem_we, instr_count); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (state !== 4'd1) $display("FAIL rst_release: state=%0d exp 1", state); else n_pass++;
  endtask

  task automatic test_wrap_jal();
    do_reset();
    opcode = 6'b000010; mem_ready = 1'b0;
    step();
    force dut.instr_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.instr_count_q;
    #1;
    n_total++; if (instr_count !== 32'hFFFF_FFFE) $display("FAIL preload: cnt=%h exp fffffffe", instr_count); else n_pass++;
    mem_ready = 1'b1;
    step(); step();
    n_total++; if (state !== 4'd12 || pc_src !== 2'b10 || pc_write !== 1'b1 || instr_done !== 1'b1 || reg_write !== 1'b0) $display("FAIL jump: state=%0d src=%b pcw=%b done=%b exp 12/10/1/1", state, pc_src, pc_write, instr_done); else n_pass++;
    step();
    n_total++; if (instr_count !== 32'hFFFF_FFFF) $display("FAIL cnt_max: cnt=%h exp ffffffff", instr_count); else n_pass++;
    step(); step(); step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd0) $display("FAIL cnt_wrap: state=%0d cnt=%h exp 1/0", state, instr_count); else n_pass++;
    opcode = 6'b000011;
    step(); step();
    n_total++; if (state !== 4'd13 || reg_dst !== 2'b10 || mem_to_reg !== 2'b10 || pc_write !== 1'b1 || reg_write !== 1'b1 || pc_src !== 2'b10) $display("FAIL jal: state=%0d dst=%b m2r=%b pcw=%b rw=%b exp 13/10/10/1/1", state, reg_dst, mem_to_reg, pc_write, reg_write); else n_pass++;
    step();
    n_total++; if (state !== 4'd1 || instr_count !== 32'd1) $display("FAIL jal_ret: state=%0d cnt=%0d exp 1/1", state, instr_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_itype();
    test_branch();
    test_trap();
    test_reset_mid_mem();
    test_wrap_jal();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
